// File: rtl/pulse_identifier.sv
// pulse_identifier
// Pairs two consecutive decoded sweeps that share a polynomial into a
// (pulse_id_0, pulse_id_1, polynomial) record, holds it with data_availible
// until the downstream transmitter acknowledges, and counts discarded sweeps.
module pulse_identifier #(
  parameter int unsigned WIDTH          = 17,
  parameter int unsigned TIMEOUT_CYCLES = 120000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic             clk_12MHz,
  input  logic             reset,
  input  logic             sweep_valid,
  input  logic [WIDTH-1:0] sweep_offset,
  input  logic [WIDTH-1:0] sweep_poly,
  input  logic             reset_pulse_identifier,
  output logic             data_availible,
  output logic [WIDTH-1:0] pulse_id_0,
  output logic [WIDTH-1:0] pulse_id_1,
  output logic [WIDTH-1:0] polynomial,
  output logic [7:0]       dropped_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SECOND,
    S_FULL
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_avail;
  logic [WIDTH-1:0] r_id0;
  logic [WIDTH-1:0] r_id1;
  logic [WIDTH-1:0] r_poly;
  logic [7:0]       r_dropped;

  logic w_timeout;
  logic w_poly_match;
  logic w_drop;

  assign w_timeout    = (r_timer == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_poly_match = (sweep_poly == r_poly);

  // A sweep is lost when it arrives while a record is held, when it displaces
  // an unmatched first sweep, or when the first sweep ages out unpaired.
  always_comb begin
    w_drop = 1'b0;
    case (r_state)
      S_WAIT_SECOND: w_drop = sweep_valid ? !w_poly_match : w_timeout;
      S_FULL:        w_drop = sweep_valid;
      default:       w_drop = 1'b0;
    endcase
  end

  // Pairing state machine with registered record outputs.
  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_avail <= 1'b0;
      r_id0   <= '0;
      r_id1   <= '0;
      r_poly  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sweep_valid) begin
            r_id0   <= sweep_offset;
            r_poly  <= sweep_poly;
            r_timer <= '0;
            r_state <= S_WAIT_SECOND;
          end
        end
        S_WAIT_SECOND: begin
          // An arriving sweep takes priority over the timeout in the same cycle.
          if (sweep_valid) begin
            if (w_poly_match) begin
              r_id1   <= sweep_offset;
              r_avail <= 1'b1;
              r_state <= S_FULL;
            end else begin
              r_id0   <= sweep_offset;
              r_poly  <= sweep_poly;
              r_timer <= '0;
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        S_FULL: begin
          if (reset_pulse_identifier) begin
            r_avail <= 1'b0;
            r_id0   <= '0;
            r_id1   <= '0;
            r_poly  <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of discarded sweeps; only reset clears it.
  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      r_dropped <= '0;
    end else if (w_drop && (r_dropped != 8'hFF)) begin
      r_dropped <= r_dropped + 8'd1;
    end
  end

  assign data_availible = r_avail;
  assign pulse_id_0     = r_id0;
  assign pulse_id_1     = r_id1;
  assign polynomial     = r_poly;
  assign dropped_count  = r_dropped;

endmodule

// File: tb/tb_pulse_identifier.sv
// Bench for pulse_identifier: directed scenarios plus randomized traffic,
// every cycle compared against an event-level reference model.
module tb_pulse_identifier;

  localparam int unsigned W  = 17;
  localparam int unsigned T  = 600;
  localparam int unsigned CW = 10;

  localparam logic [W-1:0] P1 = 17'h0D83F;
  localparam logic [W-1:0] P2 = 17'h12345;

  logic         clk_12MHz = 1'b0;
  logic         reset = 1'b1;
  logic         sweep_valid = 1'b0;
  logic [W-1:0] sweep_offset = '0;
  logic [W-1:0] sweep_poly = '0;
  logic         reset_pulse_identifier = 1'b0;
  logic         data_availible;
  logic [W-1:0] pulse_id_0;
  logic [W-1:0] pulse_id_1;
  logic [W-1:0] polynomial;
  logic [7:0]   dropped_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a pending first sweep with its arrival time, a held record.
  bit           m_first;
  bit           m_rec;
  int           m_cyc;
  int           m_t0;
  logic [W-1:0] m_id0, m_id1, m_poly;
  int           m_drop;

  pulse_identifier #(
    .WIDTH(W),
    .TIMEOUT_CYCLES(T),
    .CNT_W(CW)
  ) dut (
    .clk_12MHz(clk_12MHz),
    .reset(reset),
    .sweep_valid(sweep_valid),
    .sweep_offset(sweep_offset),
    .sweep_poly(sweep_poly),
    .reset_pulse_identifier(reset_pulse_identifier),
    .data_availible(data_availible),
    .pulse_id_0(pulse_id_0),
    .pulse_id_1(pulse_id_1),
    .polynomial(polynomial),
    .dropped_count(dropped_count)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_first = 0; m_rec = 0; m_cyc = 0; m_t0 = 0;
    m_id0 = '0; m_id1 = '0; m_poly = '0; m_drop = 0;
  endtask

  task automatic model_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] off, input logic [W-1:0] poly,
                            input bit ack);
    m_cyc++;
    if (m_rec) begin
      if (v) model_drop();
      if (ack) begin
        m_rec = 0; m_id0 = '0; m_id1 = '0; m_poly = '0;
      end
    end else if (m_first) begin
      if (v) begin
        if (poly == m_poly) begin
          m_id1 = off; m_rec = 1; m_first = 0;
        end else begin
          model_drop();
          m_id0 = off; m_poly = poly; m_t0 = m_cyc;
        end
      end else if (m_cyc - m_t0 == T) begin
        model_drop();
        m_first = 0;
      end
    end else if (v) begin
      m_id0 = off; m_poly = poly; m_first = 1; m_t0 = m_cyc;
    end
  endtask

  task automatic compare_all();
    check("avail", {31'b0, data_availible}, {31'b0, m_rec});
    check("id0", {15'b0, pulse_id_0}, {15'b0, m_id0});
    check("id1", {15'b0, pulse_id_1}, {15'b0, m_id1});
    check("poly", {15'b0, polynomial}, {15'b0, m_poly});
    check("dropped", {24'b0, dropped_count}, m_drop);
  endtask

  // One clock cycle of stimulus; outputs checked 1 time unit after the edge.
  task automatic tick(input bit v, input logic [W-1:0] off, input logic [W-1:0] poly,
                      input bit ack);
    sweep_valid = v;
    sweep_offset = off;
    sweep_poly = poly;
    reset_pulse_identifier = ack;
    @(posedge clk_12MHz);
    model_step(v, off, poly, ack);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, '0, '0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear with no edge.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    sweep_valid = 0;
    reset_pulse_identifier = 0;
    @(posedge clk_12MHz);
    #1;
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    model_reset();
    @(posedge clk_12MHz);
    #1;
    compare_all();
    reset = 1'b0;
    idle(2);

    // 1: basic pair, hold, ack
    tick(1, 17'h00123, P1, 0);
    idle(499);
    tick(1, 17'h01ABC, P1, 0);
    check("t1_avail", {31'b0, data_availible}, 32'd1);
    check("t1_id0", {15'b0, pulse_id_0}, 32'h00123);
    check("t1_id1", {15'b0, pulse_id_1}, 32'h01ABC);
    check("t1_poly", {15'b0, polynomial}, 32'h0D83F);
    idle(20);
    tick(0, '0, '0, 1);
    check("t1_ack_avail", {31'b0, data_availible}, 32'd0);
    check("t1_ack_id0", {15'b0, pulse_id_0}, 32'd0);

    // 2: timeout, then pairing at the last allowed cycle
    pulse_reset();
    tick(1, 17'h00055, P1, 0);
    idle(T);
    check("t2_drop", {24'b0, dropped_count}, 32'd1);
    check("t2_avail", {31'b0, data_availible}, 32'd0);
    tick(1, 17'h00077, P2, 0);
    idle(T - 1);
    tick(1, 17'h00088, P2, 0);
    check("t2_edge_avail", {31'b0, data_availible}, 32'd1);
    check("t2_edge_id1", {15'b0, pulse_id_1}, 32'h00088);
    tick(0, '0, '0, 1);

    // 3: polynomial mismatch replaces the first sweep
    pulse_reset();
    tick(1, 17'h0000A, P1, 0);
    idle(3);
    tick(1, 17'h0000B, P2, 0);
    idle(3);
    tick(1, 17'h0000C, P2, 0);
    check("t3_id0", {15'b0, pulse_id_0}, 32'h0000B);
    check("t3_id1", {15'b0, pulse_id_1}, 32'h0000C);
    check("t3_poly", {15'b0, polynomial}, {15'b0, P2});
    check("t3_drop", {24'b0, dropped_count}, 32'd1);

    // 4: busy record discards sweeps; ack wins over a same-cycle sweep
    pulse_reset();
    tick(1, 17'h00111, P1, 0);
    tick(1, 17'h00222, P1, 0);
    for (int i = 0; i < 3; i++) tick(1, 17'h1FFFF, P1, 0);
    check("t4_hold_id0", {15'b0, pulse_id_0}, 32'h00111);
    tick(1, 17'h1EEEE, P1, 1);
    check("t4_drop", {24'b0, dropped_count}, 32'd4);
    check("t4_avail", {31'b0, data_availible}, 32'd0);
    tick(1, 17'h00333, P2, 0);
    tick(1, 17'h00444, P2, 0);
    check("t4_new_id0", {15'b0, pulse_id_0}, 32'h00333);
    check("t4_new_id1", {15'b0, pulse_id_1}, 32'h00444);
    tick(0, '0, '0, 1);

    // 5: saturation of the drop counter
    pulse_reset();
    tick(1, 17'h00001, P1, 0);
    tick(1, 17'h00002, P1, 0);
    for (int i = 0; i < 300; i++) tick(1, 17'(i), P1, 0);
    check("t5_sat", {24'b0, dropped_count}, 32'hFF);
    tick(0, '0, '0, 1);

    // 6: async reset in WAIT_SECOND and in FULL, then a fresh pair
    pulse_reset();
    tick(1, 17'h00ABC, P1, 0);
    idle(2);
    pulse_reset();
    check("t6_wait_id0", {15'b0, pulse_id_0}, 32'd0);
    tick(1, 17'h00D00, P1, 0);
    tick(1, 17'h00D01, P1, 0);
    pulse_reset();
    check("t6_full_avail", {31'b0, data_availible}, 32'd0);
    tick(1, 17'h00E00, P2, 0);
    idle(5);
    tick(1, 17'h00E01, P2, 0);
    check("t6_fresh_id1", {15'b0, pulse_id_1}, 32'h00E01);
    tick(0, '0, '0, 1);

    // Randomized traffic with occasional long gaps around the timeout boundary
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 999);
      if (r < 8) begin
        idle(int'($urandom_range(T - 3, T + 3)));
      end else if (r < 10) begin
        pulse_reset();
      end else begin
        bit v, ack;
        logic [W-1:0] off, poly;
        v    = ($urandom_range(0, 99) < 25);
        ack  = ($urandom_range(0, 99) < 20);
        off  = W'($urandom);
        poly = ($urandom_range(0, 2) == 0) ? P2 : P1;
        tick(v, off, poly, ack);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
